// File: rtl/dram_cache_pkg.sv
// dram_cache_pkg
//   Shared constants, the cache line type and the controller state encoding
//   for dram_line_cache and its line-merge helper.
`timescale 1ns/1ps
package dram_cache_pkg;

  localparam int LINE_BITS      = 128;
  localparam int WORD_BITS      = 16;
  localparam int WORDS_PER_LINE = 8;
  localparam int OFFSET_BITS    = 3;
  localparam int INDEX_BITS     = 9;
  localparam int TAG_BITS       = 13;

  typedef logic [LINE_BITS-1:0] line_t;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS_REQ,
    ST_MISS_WAIT,
    ST_FILL
  } state_e;

endpackage

// File: rtl/dram_cache_line_merge.sv
// dram_cache_line_merge
//   Combinational byte merge of one CPU word into a cache line, plus
//   selection of the addressed word from the merged result.
//   line_i   : source line (RAM output or DRAM fill data)
//   offset_i : word-in-line, word 0 is bits [15:0]
//   wdata_i  : CPU write data
//   wmask_i  : byte enables ([1] upper, [0] lower); 0 for reads
//   line_o   : merged line
//   word_o   : word at offset_i of the merged line
`timescale 1ns/1ps
module dram_cache_line_merge
  import dram_cache_pkg::*;
(
  input  line_t                  line_i,
  input  logic [OFFSET_BITS-1:0] offset_i,
  input  logic [WORD_BITS-1:0]   wdata_i,
  input  logic [1:0]             wmask_i,
  output line_t                  line_o,
  output logic [WORD_BITS-1:0]   word_o
);

  logic [WORD_BITS-1:0] words [WORDS_PER_LINE];

  generate
    for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_word
      logic sel;
      assign sel = (offset_i == OFFSET_BITS'(gi));
      assign line_o[gi*WORD_BITS +: 8] =
        (sel && wmask_i[0]) ? wdata_i[7:0] : line_i[gi*WORD_BITS +: 8];
      assign line_o[gi*WORD_BITS+8 +: 8] =
        (sel && wmask_i[1]) ? wdata_i[15:8] : line_i[gi*WORD_BITS+8 +: 8];
      assign words[gi] = line_o[gi*WORD_BITS +: WORD_BITS];
    end
  endgenerate

  assign word_o = words[offset_i];

endmodule

// File: rtl/dram_line_cache.sv
// dram_line_cache
//   Direct-mapped write-back cache of 512 x 128-bit lines serving 16-bit CPU
//   accesses. A miss issues one combined fill-read / victim-writeback request
//   to dram_controller, then fills the line and completes the CPU access.
// Ports:
//   main_clk, reset         : clock, synchronous active-high reset
//   cpu_*                   : CPU word port (req pulse, ready, ack pulse, data)
//   addr_req_*, lane_to_dram, entry_dirty, req_read_pulse : DRAM request side,
//                             held stable from request until the DRAM ack
//   lane_from_dram, ack_read_pulse : DRAM fill data and completion pulse
//   stat_hits/stat_misses/stat_writebacks : only with DRAM_LINE_CACHE_STATS_EN
// Optional feature macro: DRAM_LINE_CACHE_STATS_EN (32-bit event counters).
`timescale 1ns/1ps
module dram_line_cache
  import dram_cache_pkg::*;
#(
  parameter int INDEX_BITS = 9,   // fixed by the DRAM address split
  parameter int TAG_BITS   = 13   // equals the DRAM upper address width
) (
  input  logic                                    main_clk,
  input  logic                                    reset,
  output logic                                    cpu_ready,
  input  logic                                    cpu_req,
  input  logic                                    cpu_we,
  input  logic [TAG_BITS+INDEX_BITS+OFFSET_BITS-1:0] cpu_addr,
  input  logic [WORD_BITS-1:0]                    cpu_wdata,
  input  logic [1:0]                              cpu_wmask,
  output logic [WORD_BITS-1:0]                    cpu_rdata,
  output logic                                    cpu_ack,
  output logic [TAG_BITS-1:0]                     addr_req_read_upper,
  output logic [TAG_BITS-1:0]                     addr_req_write_upper,
  output logic [INDEX_BITS-1:0]                   addr_req_common,
  output line_t                                   lane_to_dram,
  input  line_t                                   lane_from_dram,
  output logic                                    entry_dirty,
  output logic                                    req_read_pulse,
  input  logic                                    ack_read_pulse
`ifdef DRAM_LINE_CACHE_STATS_EN
  ,
  output logic [31:0]                             stat_hits,
  output logic [31:0]                             stat_misses,
  output logic [31:0]                             stat_writebacks
`endif
);

  localparam int NUM_LINES = 1 << INDEX_BITS;
  localparam int ADDR_BITS = TAG_BITS + INDEX_BITS + OFFSET_BITS;

  state_e state_q, state_d;
  logic [INDEX_BITS-1:0] sweep_q, sweep_d;

  // Latched CPU request
  logic                   we_q, we_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [WORD_BITS-1:0]   wdata_q, wdata_d;
  logic [1:0]             wmask_q, wmask_d;

  // Registered outputs
  logic [WORD_BITS-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                   cpu_ack_q, cpu_ack_d;
  logic [TAG_BITS-1:0]    rd_upper_q, rd_upper_d;
  logic [TAG_BITS-1:0]    wr_upper_q, wr_upper_d;
  logic [INDEX_BITS-1:0]  common_q, common_d;
  line_t                  lane_q, lane_d;
  logic                   entry_dirty_q, entry_dirty_d;
  logic                   req_pulse_q, req_pulse_d;

  // Storage
  line_t                  data_mem [NUM_LINES];
  logic [TAG_BITS-1:0]    tag_mem  [NUM_LINES];
  logic [NUM_LINES-1:0]   valid_q;
  logic [NUM_LINES-1:0]   dirty_q;
  line_t                  rd_line_q;
  logic [TAG_BITS-1:0]    rd_tag_q;

  // Write/lookup controls
  logic                   rd_en;
  logic                   data_we;
  logic                   tag_we;
  logic                   meta_we;
  logic [INDEX_BITS-1:0]  meta_idx;
  logic                   meta_valid;
  logic                   meta_dirty;

  logic [INDEX_BITS-1:0]  cpu_idx;
  logic [INDEX_BITS-1:0]  req_idx;
  logic [TAG_BITS-1:0]    req_tag;
  logic [OFFSET_BITS-1:0] req_off;
  logic                   hit;
  line_t                  merge_src;
  logic [1:0]             merge_mask;
  line_t                  merged_line;
  logic [WORD_BITS-1:0]   merged_word;

  assign cpu_idx = cpu_addr[OFFSET_BITS +: INDEX_BITS];
  assign req_idx = addr_q[OFFSET_BITS +: INDEX_BITS];
  assign req_tag = addr_q[ADDR_BITS-1 -: TAG_BITS];
  assign req_off = addr_q[OFFSET_BITS-1:0];
  assign hit     = valid_q[req_idx] && (rd_tag_q == req_tag);

  // One merge unit serves both the write hit (RAM line) and the fill
  // (DRAM line); reads pass a zero mask so only word selection happens.
  assign merge_src  = (state_q == ST_FILL) ? lane_from_dram : rd_line_q;
  assign merge_mask = we_q ? wmask_q : 2'b00;

  dram_cache_line_merge u_merge (
    .line_i   (merge_src),
    .offset_i (req_off),
    .wdata_i  (wdata_q),
    .wmask_i  (merge_mask),
    .line_o   (merged_line),
    .word_o   (merged_word)
  );

  // Data and tag RAMs: reads are issued only on request acceptance, writes
  // only in LOOKUP/FILL, so a read never collides with a write to the same
  // entry on the same edge.
  always_ff @(posedge main_clk) begin
    if (data_we) begin
      data_mem[req_idx] <= merged_line;
    end
    if (tag_we) begin
      tag_mem[req_idx] <= req_tag;
    end
    if (rd_en) begin
      rd_line_q <= data_mem[cpu_idx];
      rd_tag_q  <= tag_mem[cpu_idx];
    end
  end

  // valid/dirty are cleared by the INIT sweep rather than by reset.
  always_ff @(posedge main_clk) begin
    if (meta_we) begin
      valid_q[meta_idx] <= meta_valid;
      dirty_q[meta_idx] <= meta_dirty;
    end
  end

  always_ff @(posedge main_clk) begin
    if (reset) begin
      state_q       <= ST_INIT;
      sweep_q       <= '0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wmask_q       <= '0;
      cpu_rdata_q   <= '0;
      cpu_ack_q     <= 1'b0;
      rd_upper_q    <= '0;
      wr_upper_q    <= '0;
      common_q      <= '0;
      lane_q        <= '0;
      entry_dirty_q <= 1'b0;
      req_pulse_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      sweep_q       <= sweep_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wmask_q       <= wmask_d;
      cpu_rdata_q   <= cpu_rdata_d;
      cpu_ack_q     <= cpu_ack_d;
      rd_upper_q    <= rd_upper_d;
      wr_upper_q    <= wr_upper_d;
      common_q      <= common_d;
      lane_q        <= lane_d;
      entry_dirty_q <= entry_dirty_d;
      req_pulse_q   <= req_pulse_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    sweep_d       = sweep_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wmask_d       = wmask_q;
    cpu_rdata_d   = cpu_rdata_q;
    cpu_ack_d     = 1'b0;
    rd_upper_d    = rd_upper_q;
    wr_upper_d    = wr_upper_q;
    common_d      = common_q;
    lane_d        = lane_q;
    entry_dirty_d = entry_dirty_q;
    req_pulse_d   = 1'b0;
    rd_en         = 1'b0;
    data_we       = 1'b0;
    tag_we        = 1'b0;
    meta_we       = 1'b0;
    meta_idx      = req_idx;
    meta_valid    = 1'b0;
    meta_dirty    = 1'b0;

    case (state_q)
      ST_INIT: begin
        meta_we  = 1'b1;
        meta_idx = sweep_q;
        sweep_d  = sweep_q + 1'b1;
        if (sweep_q == '1) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (cpu_req) begin
          rd_en   = 1'b1;
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          wmask_d = cpu_wmask;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (hit) begin
          cpu_ack_d   = 1'b1;
          cpu_rdata_d = merged_word;
          if (we_q) begin
            data_we    = 1'b1;
            meta_we    = 1'b1;
            meta_valid = 1'b1;
            meta_dirty = 1'b1;
          end
          state_d = ST_IDLE;
        end else begin
          // The DRAM-side registers are loaded here so they present the
          // request in MISS_REQ and then hold through MISS_WAIT.
          rd_upper_d    = req_tag;
          wr_upper_d    = rd_tag_q;
          common_d      = req_idx;
          lane_d        = rd_line_q;
          entry_dirty_d = valid_q[req_idx] & dirty_q[req_idx];
          req_pulse_d   = 1'b1;
          state_d       = ST_MISS_REQ;
        end
      end
      ST_MISS_REQ: begin
        state_d = ST_MISS_WAIT;
      end
      ST_MISS_WAIT: begin
        if (ack_read_pulse) begin
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        data_we     = 1'b1;
        tag_we      = 1'b1;
        meta_we     = 1'b1;
        meta_valid  = 1'b1;
        meta_dirty  = we_q;
        cpu_ack_d   = 1'b1;
        cpu_rdata_d = merged_word;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  assign cpu_ready            = (state_q == ST_IDLE);
  assign cpu_rdata            = cpu_rdata_q;
  assign cpu_ack              = cpu_ack_q;
  assign addr_req_read_upper  = rd_upper_q;
  assign addr_req_write_upper = wr_upper_q;
  assign addr_req_common      = common_q;
  assign lane_to_dram         = lane_q;
  assign entry_dirty          = entry_dirty_q;
  assign req_read_pulse       = req_pulse_q;

`ifdef DRAM_LINE_CACHE_STATS_EN
  logic [31:0] hits_q;
  logic [31:0] misses_q;
  logic [31:0] writebacks_q;

  always_ff @(posedge main_clk) begin
    if (reset) begin
      hits_q       <= '0;
      misses_q     <= '0;
      writebacks_q <= '0;
    end else begin
      if (state_q == ST_LOOKUP && hit) begin
        hits_q <= hits_q + 32'd1;
      end
      if (state_q == ST_MISS_REQ) begin
        misses_q <= misses_q + 32'd1;
        if (entry_dirty_q) begin
          writebacks_q <= writebacks_q + 32'd1;
        end
      end
    end
  end

  assign stat_hits       = hits_q;
  assign stat_misses     = misses_q;
  assign stat_writebacks = writebacks_q;
`endif

endmodule

// File: tb/tb_dram_line_cache.sv
`timescale 1ns/1ps
module tb_dram_line_cache;

  logic         main_clk;
  logic         reset;
  logic         cpu_ready;
  logic         cpu_req;
  logic         cpu_we;
  logic [24:0]  cpu_addr;
  logic [15:0]  cpu_wdata;
  logic [1:0]   cpu_wmask;
  logic [15:0]  cpu_rdata;
  logic         cpu_ack;
  logic [12:0]  addr_req_read_upper;
  logic [12:0]  addr_req_write_upper;
  logic [8:0]   addr_req_common;
  logic [127:0] lane_to_dram;
  logic [127:0] lane_from_dram;
  logic         entry_dirty;
  logic         req_read_pulse;
  logic         ack_read_pulse;
`ifdef DRAM_LINE_CACHE_STATS_EN
  logic [31:0]  stat_hits;
  logic [31:0]  stat_misses;
  logic [31:0]  stat_writebacks;
`endif

  dram_line_cache dut (
    .main_clk             (main_clk),
    .reset                (reset),
    .cpu_ready            (cpu_ready),
    .cpu_req              (cpu_req),
    .cpu_we               (cpu_we),
    .cpu_addr             (cpu_addr),
    .cpu_wdata            (cpu_wdata),
    .cpu_wmask            (cpu_wmask),
    .cpu_rdata            (cpu_rdata),
    .cpu_ack              (cpu_ack),
    .addr_req_read_upper  (addr_req_read_upper),
    .addr_req_write_upper (addr_req_write_upper),
    .addr_req_common      (addr_req_common),
    .lane_to_dram         (lane_to_dram),
    .lane_from_dram       (lane_from_dram),
    .entry_dirty          (entry_dirty),
    .req_read_pulse       (req_read_pulse),
    .ack_read_pulse       (ack_read_pulse)
`ifdef DRAM_LINE_CACHE_STATS_EN
    ,
    .stat_hits            (stat_hits),
    .stat_misses          (stat_misses),
    .stat_writebacks      (stat_writebacks)
`endif
  );

  initial main_clk = 1'b0;
  always #5 main_clk = ~main_clk;

  int cyc = 0;
  always @(posedge main_clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // CPU-side scoreboard
  typedef struct {
    logic [15:0] rdata;
    bit          chk_data;
    int          lat;
    int          t0;
  } cpu_exp_t;
  cpu_exp_t rdq[$];

  // DRAM-side expectations and responder programming
  typedef struct {
    logic [12:0]  rd_up;
    logic [12:0]  wr_up;
    bit           chk_wr;
    logic [8:0]   com;
    logic         dirty;
    logic [127:0] lane;
    bit           chk_lane;
    logic [127:0] fill;
    int           delay;
  } dram_exp_t;
  dram_exp_t dq[$];

  bit auto_dram  = 1'b1;
  int pulses     = 0;
  int stray_req  = 0;
  int stray_done = 0;

  // Completion monitor
  always @(negedge main_clk) begin
    if (cpu_ack) begin
      if (rdq.size() == 0) begin
        check("unexpected_ack", 1'b1, 1'b0);
      end else begin
        cpu_exp_t e;
        e = rdq.pop_front();
        $display("ack  t=%0d rdata=%h", cyc, cpu_rdata);
        if (e.chk_data) check("rdata", cpu_rdata, e.rdata);
        if (e.lat >= 0) check("ack_latency", cyc - e.t0, e.lat);
      end
    end
  end

  // DRAM responder
  initial begin
    ack_read_pulse = 1'b0;
    lane_from_dram = '0;
    forever begin
      @(negedge main_clk);
      ack_read_pulse = 1'b0;
      if (stray_req != stray_done) begin
        ack_read_pulse = 1'b1;
        stray_done++;
      end else if (req_read_pulse) begin
        pulses++;
        if (auto_dram) begin
          if (dq.size() == 0) begin
            check("unexpected_dram_req", 1'b1, 1'b0);
          end else begin
            dram_exp_t d;
            logic [12:0]  s_rd, s_wr;
            logic [8:0]   s_com;
            logic [127:0] s_lane;
            logic         s_dirty;
            bit           stable;
            d = dq.pop_front();
            $display("dram t=%0d rd=%h wr=%h com=%h dirty=%b", cyc, addr_req_read_upper,
                     addr_req_write_upper, addr_req_common, entry_dirty);
            check("read_upper", addr_req_read_upper, d.rd_up);
            check("common", addr_req_common, d.com);
            check("entry_dirty", entry_dirty, d.dirty);
            if (d.chk_wr) check("write_upper", addr_req_write_upper, d.wr_up);
            if (d.chk_lane) check("lane_to_dram", lane_to_dram, d.lane);
            s_rd = addr_req_read_upper; s_wr = addr_req_write_upper;
            s_com = addr_req_common; s_lane = lane_to_dram; s_dirty = entry_dirty;
            stable = 1'b1;
            for (int k = 0; k < d.delay; k++) begin
              @(negedge main_clk);
              if (req_read_pulse || addr_req_read_upper !== s_rd || addr_req_write_upper !== s_wr ||
                  addr_req_common !== s_com || lane_to_dram !== s_lane || entry_dirty !== s_dirty)
                stable = 1'b0;
            end
            check("dram_outputs_stable", stable, 1'b1);
            ack_read_pulse = 1'b1;
            lane_from_dram = d.fill;
          end
        end
      end
    end
  end

  task automatic exp_miss(input logic [12:0] rd_up, input logic [12:0] wr_up, input bit chk_wr,
                          input logic [8:0] com, input logic dirty, input logic [127:0] lane,
                          input bit chk_lane, input logic [127:0] fill, input int delay);
    dram_exp_t d;
    d.rd_up = rd_up; d.wr_up = wr_up; d.chk_wr = chk_wr; d.com = com; d.dirty = dirty;
    d.lane = lane; d.chk_lane = chk_lane; d.fill = fill; d.delay = delay;
    dq.push_back(d);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cpu_ready && n < 1000) begin
      @(negedge main_clk);
      n++;
    end
    if (n >= 1000) check("ready_timeout", 1'b0, 1'b1);
  endtask

  // Issue one CPU access (called at a negedge) and wait for its ack.
  task automatic cpu_access(input bit we, input logic [24:0] a, input logic [15:0] wd,
                            input logic [1:0] wm, input logic [15:0] exp, input bit chk, input int lat);
    cpu_exp_t e;
    int n;
    wait_ready();
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_wmask = wm;
    e.rdata = exp; e.chk_data = chk; e.lat = lat; e.t0 = cyc;
    rdq.push_back(e);
    $display("req  t=%0d we=%b addr=%h wdata=%h wmask=%b", cyc, we, a, wd, wm);
    @(negedge main_clk);
    cpu_req = 1'b0;
    n = 0;
    while (rdq.size() != 0 && n < 500) begin
      @(negedge main_clk);
      n++;
    end
    if (rdq.size() != 0) begin
      check("ack_timeout", 1'b0, 1'b1);
      rdq.delete();
    end
  endtask

  localparam logic [127:0] FILL1  = 128'h0007_0006_0005_0004_0003_0002_0001_BEEF;
  localparam logic [127:0] LINE1W = 128'h0007_0006_0005_0004_0003_0002_1234_BEEF;
  localparam logic [127:0] FILL2  = 128'h1111_2222_3333_4444_5555_6666_5A5A_7777;
  localparam logic [127:0] FILL3  = {8{16'hFFFF}};
  localparam logic [127:0] LINE3W = {{7{16'hFFFF}}, 16'hFF55};
  localparam logic [127:0] FILL4  = {{7{16'h4444}}, 16'h4040};
  localparam logic [127:0] FILL5  = {16'h9ABC, {7{16'h1357}}};
  localparam logic [127:0] FILL6  = {16'h2468, 112'h0};
  localparam logic [127:0] FILL7  = {112'h0, 16'h0F0F};

  initial begin
    int n;
    int p0;
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wmask = '0;
    repeat (3) @(negedge main_clk);
    check("rst_cpu_ready", cpu_ready, 1'b0);
    check("rst_cpu_ack", cpu_ack, 1'b0);
    check("rst_cpu_rdata", cpu_rdata, 16'h0);
    check("rst_req_pulse", req_read_pulse, 1'b0);
    check("rst_entry_dirty", entry_dirty, 1'b0);
    check("rst_read_upper", addr_req_read_upper, 13'h0);
    check("rst_write_upper", addr_req_write_upper, 13'h0);
    check("rst_common", addr_req_common, 9'h0);
    check("rst_lane", lane_to_dram, 128'h0);

    // INIT sweep: count not-ready cycles, with a stray request in the middle
    reset = 1'b0;
    n = 0;
    while (!cpu_ready && n < 2000) begin
      cpu_req  = (n == 100);
      cpu_addr = 25'h0001238;
      @(negedge main_clk);
      n++;
    end
    cpu_req = 1'b0;
    check("init_ready_cycles", n, 512);
    repeat (3) @(negedge main_clk);

    // Cold read miss, then read hit, write hit, dirty eviction
    exp_miss(13'h0001, 13'h0, 1'b0, 9'h047, 1'b0, '0, 1'b0, FILL1, 3);
    cpu_access(1'b0, 25'h0001238, 16'h0, 2'b00, 16'hBEEF, 1'b1, -1);
    cpu_access(1'b0, 25'h0001238, 16'h0, 2'b00, 16'hBEEF, 1'b1, 2);
    cpu_access(1'b1, 25'h0001239, 16'h1234, 2'b11, 16'h0, 1'b0, 2);
    exp_miss(13'h1001, 13'h0001, 1'b1, 9'h047, 1'b1, LINE1W, 1'b1, FILL2, 40);
    cpu_access(1'b0, 25'h1001239, 16'h0, 2'b00, 16'h5A5A, 1'b1, -1);

    // Write miss with lower-byte mask, then hit and dirty eviction
    exp_miss(13'h0002, 13'h0, 1'b0, 9'h082, 1'b0, '0, 1'b0, FILL3, 2);
    cpu_access(1'b1, 25'h0002410, 16'hAB55, 2'b01, 16'hFF55, 1'b1, -1);
    cpu_access(1'b0, 25'h0002410, 16'h0, 2'b00, 16'hFF55, 1'b1, 2);
    exp_miss(13'h0003, 13'h0002, 1'b1, 9'h082, 1'b1, LINE3W, 1'b1, FILL4, 1);
    cpu_access(1'b0, 25'h0003410, 16'h0, 2'b00, 16'h4040, 1'b1, -1);

    // Stray DRAM ack while idle must do nothing
    stray_req++;
    repeat (4) @(negedge main_clk);
    check("stray_ack_ready", cpu_ready, 1'b1);

    // Index 511 / offset 7, zero-mask write still dirties the line
    exp_miss(13'h0005, 13'h0, 1'b0, 9'h1FF, 1'b0, '0, 1'b0, FILL5, 2);
    cpu_access(1'b0, 25'h0005FFF, 16'h0, 2'b00, 16'h9ABC, 1'b1, -1);
    cpu_access(1'b1, 25'h0005FFF, 16'hDEAD, 2'b00, 16'h0, 1'b0, 2);
    exp_miss(13'h0006, 13'h0005, 1'b1, 9'h1FF, 1'b1, FILL5, 1'b1, FILL6, 2);
    cpu_access(1'b0, 25'h0006FFF, 16'h0, 2'b00, 16'h2468, 1'b1, -1);

    // Reset while waiting for DRAM; late ack ignored, no reissue
    auto_dram = 1'b0;
    wait_ready();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h0007238;
    @(negedge main_clk);
    cpu_req = 1'b0;
    n = 0;
    while (!req_read_pulse && n < 20) begin
      @(negedge main_clk);
      n++;
    end
    check("mid_miss_req_seen", req_read_pulse, 1'b1);
    repeat (3) @(negedge main_clk);
    p0 = pulses;
    reset = 1'b1;
    repeat (2) @(negedge main_clk);
    check("mid_rst_ready", cpu_ready, 1'b0);
    check("mid_rst_req_pulse", req_read_pulse, 1'b0);
    reset = 1'b0;
    stray_req++;
    repeat (3) @(negedge main_clk);
    check("late_ack_in_init", cpu_ready, 1'b0);
    wait_ready();
    repeat (3) @(negedge main_clk);
    check("no_reissue", pulses, p0);
    auto_dram = 1'b1;
    exp_miss(13'h0007, 13'h0, 1'b0, 9'h047, 1'b0, '0, 1'b0, FILL7, 1);
    cpu_access(1'b0, 25'h0007238, 16'h0, 2'b00, 16'h0F0F, 1'b1, -1);

    repeat (5) @(negedge main_clk);
    check("dram_queue_drained", dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
